// File: rtl/otter_pkg.sv
// otter_pkg: shared widths, operand-select enums and ALU function encodings for the OTTER core
package otter_pkg;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {SRCA_RS1, SRCA_UIMM, SRCA_PC, SRCA_ZERO} srcA_sel_t;
  typedef enum logic [1:0] {SRCC_RS2, SRCC_IIMM, SRCC_SIMM, SRCC_FOUR} srcC_sel_t;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_LUI  = 4'b1001;
endpackage

// File: rtl/operand_fwd_mux.sv
// operand_fwd_mux: resolves one register operand from EX, WB or register-file data
// Ports: addr/rf_data = source register and its file value; ex_*/wb_* = forwarding
// sources; ex_is_load blocks EX forwarding; data = resolved operand.
module operand_fwd_mux #(
  parameter int XLEN = 32,
  parameter int RADDR_W = 5
) (
  input  logic [RADDR_W-1:0] addr,
  input  logic [XLEN-1:0]    rf_data,
  input  logic               ex_en,
  input  logic [RADDR_W-1:0] ex_rd,
  input  logic [XLEN-1:0]    ex_data,
  input  logic               ex_is_load,
  input  logic               wb_en,
  input  logic [RADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]    wb_data,
  output logic [XLEN-1:0]    data
);
  // x0 is hardwired; a load in EX has no data yet, so it never forwards
  always_comb
    data = addr == '0 ? rf_data :
           (ex_en && ex_rd == addr && !ex_is_load) ? ex_data :
           (wb_en && wb_rd == addr) ? wb_data : rf_data;
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ID/EX stage resolving, selecting and registering ALU operands
// Ports: CLK/RST_N (sync active-low); flush; in_valid/in_ready + decoded fields in;
// ex_*/wb_* forwarding and load-use info; out_valid/out_ready + ALU operands,
// function, rd, reg_write and forwarded rs2 (store data) out.
module alu_operand_stage import otter_pkg::*; #(
  parameter int XLEN = otter_pkg::XLEN,
  parameter int RADDR_W = 5
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_alu_fun,
  input  logic [1:0]         in_srcA_sel,
  input  logic [1:0]         in_srcC_sel,
  input  logic [RADDR_W-1:0] in_rs1_addr,
  input  logic [RADDR_W-1:0] in_rs2_addr,
  input  logic [RADDR_W-1:0] in_rd_addr,
  input  logic [XLEN-1:0]    in_rs1_data,
  input  logic [XLEN-1:0]    in_rs2_data,
  input  logic [XLEN-1:0]    in_u_imm,
  input  logic [XLEN-1:0]    in_i_imm,
  input  logic [XLEN-1:0]    in_s_imm,
  input  logic [XLEN-1:0]    in_pc,
  input  logic               in_reg_write,
  input  logic               ex_fwd_en,
  input  logic               wb_fwd_en,
  input  logic [RADDR_W-1:0] ex_fwd_rd,
  input  logic [RADDR_W-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0]    ex_fwd_data,
  input  logic [XLEN-1:0]    wb_fwd_data,
  input  logic               ex_is_load,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_Scr_A,
  output logic [XLEN-1:0]    out_Scr_C,
  output logic [3:0]         out_alu_fun,
  output logic [RADDR_W-1:0] out_rd_addr,
  output logic               out_reg_write,
  output logic [XLEN-1:0]    out_rs2_fwd
);
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);
  srcA_sel_t sel_a;
  srcC_sel_t sel_c;
  logic [XLEN-1:0] rs1_f, rs2_f, op_a, op_c;
  logic hazard, accept;
  assign sel_a = srcA_sel_t'(in_srcA_sel);
  assign sel_c = srcC_sel_t'(in_srcC_sel);
  operand_fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs1 (
    .addr(in_rs1_addr), .rf_data(in_rs1_data),
    .ex_en(ex_fwd_en), .ex_rd(ex_fwd_rd), .ex_data(ex_fwd_data), .ex_is_load(ex_is_load),
    .wb_en(wb_fwd_en), .wb_rd(wb_fwd_rd), .wb_data(wb_fwd_data), .data(rs1_f)
  );
  operand_fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs2 (
    .addr(in_rs2_addr), .rf_data(in_rs2_data),
    .ex_en(ex_fwd_en), .ex_rd(ex_fwd_rd), .ex_data(ex_fwd_data), .ex_is_load(ex_is_load),
    .wb_en(wb_fwd_en), .wb_rd(wb_fwd_rd), .wb_data(wb_fwd_data), .data(rs2_f)
  );
  // rs2 counts as used for S-type too, since it becomes store data
  always_comb begin
    hazard = in_valid && ex_is_load && ex_fwd_en && ex_fwd_rd != '0 &&
             ((sel_a == SRCA_RS1 && in_rs1_addr == ex_fwd_rd) ||
              ((sel_c == SRCC_RS2 || sel_c == SRCC_SIMM) && in_rs2_addr == ex_fwd_rd));
    in_ready = flush || ((!out_valid || out_ready) && !hazard);
    accept = in_valid && in_ready && !flush;
    op_a = sel_a == SRCA_RS1 ? rs1_f : sel_a == SRCA_UIMM ? in_u_imm :
           sel_a == SRCA_PC ? in_pc : '0;
    op_c = sel_c == SRCC_RS2 ? rs2_f : sel_c == SRCC_IIMM ? in_i_imm :
           sel_c == SRCC_SIMM ? in_s_imm : FOUR;
  end
  always_ff @(posedge CLK)
    if (!RST_N) begin
      out_valid <= 1'b0;
      out_Scr_A <= '0;
      out_Scr_C <= '0;
      out_alu_fun <= 4'b0000;
      out_rd_addr <= '0;
      out_reg_write <= 1'b0;
      out_rs2_fwd <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_Scr_A <= op_a;
      out_Scr_C <= op_c;
      out_alu_fun <= in_alu_fun;
      out_rd_addr <= in_rd_addr;
      out_reg_write <= in_reg_write;
      out_rs2_fwd <= rs2_f;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX pipeline stage directly upstream of the OTTER ALU.
- Resolves register operands through EX/WB forwarding, selects ALU source A and source C from register data, immediates or PC, and registers them with alu_fun.
- Sits behind a valid/ready handshake with a load-use stall and a flush.
- Registered outputs drive the ALU operand and function inputs directly.

Parameters:
- XLEN, 32, datapath width.
- RADDR_W, 5, register address width.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  synchronous active-low reset.
- flush  in  1  discard held and incoming instruction.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage can accept this cycle.
- in_alu_fun  in  4  ALU function code.
- in_srcA_sel  in  2  0=rs1, 1=u_imm, 2=pc, 3=zero.
- in_srcC_sel  in  2  0=rs2, 1=i_imm, 2=s_imm, 3=const 4.
- in_rs1_addr, in_rs2_addr, in_rd_addr  in  RADDR_W  register addresses.
- in_rs1_data, in_rs2_data  in  XLEN  register file read data.
- in_u_imm, in_i_imm, in_s_imm, in_pc  in  XLEN  pre-extended immediates and PC.
- in_reg_write  in  1  instruction writes rd.
- ex_fwd_en, wb_fwd_en  in  1  forward source valid and writing.
- ex_fwd_rd, wb_fwd_rd  in  RADDR_W  forward destination.
- ex_fwd_data, wb_fwd_data  in  XLEN  forward value.
- ex_is_load  in  1  EX instruction is a load; data not yet available.
- out_valid  out  1  operands valid to ALU.
- out_ready  in  1  downstream accepts.
- out_Scr_A, out_Scr_C  out  XLEN  ALU operands.
- out_alu_fun  out  4  function to ALU.
- out_rd_addr  out  RADDR_W  destination register.
- out_reg_write  out  1  writeback enable.
- out_rs2_fwd  out  XLEN  forwarded rs2, used as store data.

Behaviour:
- Reset: when RST_N=0 at a CLK edge, all outputs registered to 0 (out_valid=0, operands 0, out_alu_fun=4'b0000, out_rd_addr=0, out_reg_write=0).
  - Reset overrides flush and a stall.
  - Reset mid-handshake drops the held instruction.
- Single-entry register. in_ready = (!out_valid || out_ready) && !hazard.
- hazard = in_valid && ex_is_load && ex_fwd_en && ex_fwd_rd != 0 && ex_fwd_rd matches a used source.
  - rs1 is used when srcA_sel=0.
  - rs2 is used when srcC_sel=0, or always for out_rs2_fwd when srcC_sel=2.
- Accept = in_valid && in_ready. On accept, capture next-cycle values; latency is exactly 1 cycle.
- If out_valid && !out_ready: hold all outputs stable, including when in_valid changes.
- If out_valid && out_ready && !accept: out_valid goes to 0 and the data registers retain their values (don't-care).
- Hazard with an empty/draining output: out_valid goes to 0 (bubble). The upstream instruction stays pending and is re-evaluated next cycle.
- Forwarding per operand:
  - Address 0 always yields in_*_data; x0 is never forwarded.
  - EX match (ex_fwd_en && ex_fwd_rd==addr && !ex_is_load) has priority.
  - WB match is next, then register file data.
  - A load EX match never forwards; it always stalls.
- Operand select applies after forwarding. Selector codes are all defined; no undefined values.
- flush=1: out_valid goes to 0 next cycle, no accept occurs, and in_ready is forced to 1 so upstream drains.
- flush and out_ready both asserted: flush wins.
- No arithmetic in this block. Constant 4 is zero-extended to XLEN.

Decomposition:
- Package otter_pkg holds:
  - srcA_sel_t enum (SRCA_RS1, SRCA_UIMM, SRCA_PC, SRCA_ZERO).
  - srcC_sel_t enum (SRCC_RS2, SRCC_IIMM, SRCC_SIMM, SRCC_FOUR).
  - alu_fun_t localparams matching the ALU encodings (ADD 0000, SUB 1000, OR 0110, AND 0111, XOR 0100, SRL 0101, SLL 0001, SRA 1101, SLT 0010, SLTU 0011, LUI 1001).
  - XLEN.
- Sub-module operand_fwd_mux: combinational 3-way forward resolve for one operand. Instantiated twice (rs1, rs2); hazard detect stays in the top.

Test Plan:
- Reset, then in_valid=1, srcA=rs1 (rs1=5, data 0x10), srcC=i_imm 0xFFFFFFFC, alu_fun=0000, out_ready=1 -> next cycle out_valid=1, Scr_A=0x10, Scr_C=0xFFFFFFFC, alu_fun=0000.
- rs1=3 with ex_fwd_en=1, ex_fwd_rd=3, ex_fwd_data=0xAAAA, and wb_fwd_en=1, wb_fwd_rd=3, wb_fwd_data=0xBBBB -> Scr_A=0xAAAA.
- Same setup with rs1=0 -> Scr_A=in_rs1_data.
- ex_is_load=1, ex_fwd_rd=7, instruction srcC=rs2 with rs2=7 -> in_ready=0 and out_valid=0 next cycle. Drop ex_is_load and set wb_fwd_rd=7, data 0x55 -> accepted, Scr_C=0x55.
- out_ready=0 for 3 cycles with an instruction held (Scr_A=0x1234) while in_valid toggles -> outputs unchanged and in_ready=0. Raise out_ready -> the next instruction appears the cycle after.
- flush asserted with out_valid=1 and out_ready=0 -> out_valid=0 next cycle.
- RST_N=0 during a stall -> all outputs 0 next cycle, in_ready=1 after release.
